// File: rtl/tag_match_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tag_match_pkg
// Purpose  : Shared width helpers and merge-policy constants for the
//            tag-match datapath (tag_match_pipe, match_reduce).
// Revision : 1.0 - initial release
// ============================================================================
package tag_match_pkg;

  // Merge policies for the reduced payload
  localparam int MODE_OR   = 0;  // OR of every matching payload
  localparam int MODE_PRIO = 1;  // payload of the lowest-index match

  // Tag width for a tag range of 'size' values (never narrower than 1 bit)
  function automatic int tag_w(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

  // Index width for a table of 'k' entries (never narrower than 1 bit)
  function automatic int idx_w(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/match_reduce.sv
`default_nettype none
// ============================================================================
// Module   : match_reduce
// Purpose  : Combinational reduction of a match vector and its payload array
//            into hit, multi-hit, lowest matching index and merged payload.
// Revision : 1.0 - initial release
// ============================================================================
module match_reduce
  import tag_match_pkg::*;
#(
  parameter int K      = 8,
  parameter int DATA_W = idx_w(K),
  parameter int MODE   = MODE_OR,
  localparam int IDX_W = idx_w(K)
) (
  input  logic [K-1:0]        m,
  input  logic [K*DATA_W-1:0] data,
  output logic                hit,
  output logic                multi,
  output logic [IDX_W-1:0]    idx,
  output logic [DATA_W-1:0]   merged
);

  logic [DATA_W-1:0] or_data;
  logic [DATA_W-1:0] prio_data;

  // Scan upward: the first set bit fixes index and priority payload, any
  // later set bit flags a multi-hit; every set bit contributes to the OR.
  always_comb begin
    hit       = 1'b0;
    multi     = 1'b0;
    idx       = '0;
    or_data   = '0;
    prio_data = '0;
    for (int i = 0; i < K; i++) begin
      if (m[i]) begin
        if (hit) begin
          multi = 1'b1;
        end else begin
          idx       = IDX_W'(i);
          prio_data = data[i*DATA_W +: DATA_W];
        end
        hit     = 1'b1;
        or_data = or_data | data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Both candidates are zero on a miss, so no extra masking is needed
  assign merged = (MODE == MODE_PRIO) ? prio_data : or_data;

endmodule
`default_nettype wire

// File: rtl/tag_match_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tag_match_pipe
// Purpose  : K-entry (tag, payload) table with a two-stage valid/ready query
//            pipeline returning hit, multi-hit, lowest index and payload.
// Revision : 1.0 - initial release
// ============================================================================
module tag_match_pipe
  import tag_match_pkg::*;
#(
  parameter int SIZE   = 16,
  parameter int K      = 8,
  parameter int DATA_W = idx_w(K),
  parameter int MODE   = MODE_OR,
  localparam int TAG_W = tag_w(SIZE),
  localparam int IDX_W = idx_w(K)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr,
  input  logic              q_valid,
  output logic              q_ready,
  input  logic [TAG_W-1:0]  q_tag,
  output logic              r_valid,
  input  logic              r_ready,
  output logic              r_hit,
  output logic              r_multi,
  output logic [IDX_W-1:0]  r_idx,
  output logic [DATA_W-1:0] r_data
);

  logic [K-1:0]        match;
  logic [K*DATA_W-1:0] tab_flat;

  logic                s1_valid;
  logic [K-1:0]        s1_m;
  logic [K*DATA_W-1:0] s1_data;

  logic                s2_free;
  logic                advance;
  logic                accept;

  logic                red_hit;
  logic                red_multi;
  logic [IDX_W-1:0]    red_idx;
  logic [DATA_W-1:0]   red_data;

  // Each entry owns its registers; an index beyond K-1 selects no entry,
  // so out-of-range writes fall away without an explicit range check.
  for (genvar gi = 0; gi < K; gi++) begin : g_entry
    logic              e_valid;
    logic [TAG_W-1:0]  e_tag;
    logic [DATA_W-1:0] e_data;
    logic              e_sel;

    assign e_sel = wr_en && (wr_idx == IDX_W'(gi));

    // Entry update: a write to this entry beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        e_valid <= 1'b0;
        e_tag   <= '0;
        e_data  <= '0;
      end else if (e_sel) begin
        e_valid <= 1'b1;
        e_tag   <= wr_tag;
        e_data  <= wr_data;
      end else if (clr) begin
        e_valid <= 1'b0;
      end
    end

    assign match[gi]                       = e_valid && (e_tag == q_tag);
    assign tab_flat[gi*DATA_W +: DATA_W]   = e_data;
  end

  assign s2_free = !r_valid || r_ready;
  assign advance = s1_valid && s2_free;
  assign q_ready = !s1_valid || s2_free;
  assign accept  = q_valid && q_ready;

  // Stage 1: snapshot match vector and payloads from the pre-edge table
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_m     <= '0;
      s1_data  <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_m     <= match;
      s1_data  <= tab_flat;
    end else if (advance) begin
      s1_valid <= 1'b0;
    end
  end

  match_reduce #(
    .K      (K),
    .DATA_W (DATA_W),
    .MODE   (MODE)
  ) u_reduce (
    .m      (s1_m),
    .data   (s1_data),
    .hit    (red_hit),
    .multi  (red_multi),
    .idx    (red_idx),
    .merged (red_data)
  );

  // Stage 2: result registers, held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_hit   <= 1'b0;
      r_multi <= 1'b0;
      r_idx   <= '0;
      r_data  <= '0;
    end else if (advance) begin
      r_valid <= 1'b1;
      r_hit   <= red_hit;
      r_multi <= red_multi;
      r_idx   <= red_idx;
      r_data  <= red_data;
    end else if (r_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tag_match_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_tag_match_pipe
// Purpose  : Scoreboard bench for tag_match_pipe; an OR-merge and a
//            priority-merge instance share all inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tag_match_pipe;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [2:0] wr_idx;
  logic [3:0] wr_tag;
  logic [2:0] wr_data;
  logic       clr;
  logic       q_valid;
  logic [3:0] q_tag;
  logic       r_ready;

  logic       q_ready_or,  q_ready_pri;
  logic       r_valid_or,  r_valid_pri;
  logic       r_hit_or,    r_hit_pri;
  logic       r_multi_or,  r_multi_pri;
  logic [2:0] r_idx_or,    r_idx_pri;
  logic [2:0] r_data_or,   r_data_pri;

  tag_match_pipe #(.SIZE(16), .K(8), .DATA_W(3), .MODE(0)) u_or (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_tag(wr_tag),
    .wr_data(wr_data), .clr(clr), .q_valid(q_valid), .q_ready(q_ready_or),
    .q_tag(q_tag), .r_valid(r_valid_or), .r_ready(r_ready), .r_hit(r_hit_or),
    .r_multi(r_multi_or), .r_idx(r_idx_or), .r_data(r_data_or)
  );

  tag_match_pipe #(.SIZE(16), .K(8), .DATA_W(3), .MODE(1)) u_pri (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_tag(wr_tag),
    .wr_data(wr_data), .clr(clr), .q_valid(q_valid), .q_ready(q_ready_pri),
    .q_tag(q_tag), .r_valid(r_valid_pri), .r_ready(r_ready), .r_hit(r_hit_pri),
    .r_multi(r_multi_pri), .r_idx(r_idx_pri), .r_data(r_data_pri)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       hit;
    logic       multi;
    logic [2:0] idx;
    logic [2:0] d0;
    logic [2:0] d1;
    int         cyc;
    bit         lat;
  } exp_t;

  typedef struct {
    logic       hit;
    logic       multi;
    logic [2:0] idx;
    logic [2:0] d0;
    logic [2:0] d1;
  } got_t;

  exp_t sb[$];
  got_t got[$];

  bit         mv[8];
  logic [3:0] mt[8];
  logic [2:0] md[8];

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int accepts = 0;
  bit chk_lat = 1'b1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mv[i] = 1'b0;
      mt[i] = '0;
      md[i] = '0;
    end
  endtask

  task automatic push_exp(input logic [3:0] qt);
    exp_t e;
    int   cnt;
    cnt   = 0;
    e.hit = 1'b0; e.multi = 1'b0; e.idx = '0; e.d0 = '0; e.d1 = '0;
    e.cyc = cyc;  e.lat = chk_lat;
    for (int i = 0; i < 8; i++) begin
      if (mv[i] && mt[i] == qt) begin
        if (cnt == 0) begin
          e.idx = 3'(i);
          e.d1  = md[i];
        end
        cnt++;
        e.d0 = e.d0 | md[i];
      end
    end
    e.hit   = (cnt > 0);
    e.multi = (cnt >= 2);
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    got_t g;
    if (sb.size() == 0) begin
      check("sb_empty", 32'(sb.size()), 1);
      return;
    end
    e = sb.pop_front();
    check("or_hit",    r_hit_or,    e.hit);
    check("or_multi",  r_multi_or,  e.multi);
    check("or_idx",    r_idx_or,    e.idx);
    check("or_data",   r_data_or,   e.d0);
    check("pri_valid", r_valid_pri, 1);
    check("pri_hit",   r_hit_pri,   e.hit);
    check("pri_multi", r_multi_pri, e.multi);
    check("pri_idx",   r_idx_pri,   e.idx);
    check("pri_data",  r_data_pri,  e.d1);
    if (e.lat) check("latency", 32'(cyc - e.cyc), 2);
    g.hit = r_hit_or; g.multi = r_multi_or; g.idx = r_idx_or;
    g.d0  = r_data_or; g.d1 = r_data_pri;
    got.push_back(g);
  endtask

  // One clock cycle: drive at the falling edge, score, then step past the rising edge
  task automatic cycle(input bit qv, input logic [3:0] qt, input bit we,
                       input logic [2:0] wi, input logic [3:0] wt,
                       input logic [2:0] wd, input bit cl, input bit rr);
    q_valid = qv; q_tag = qt; wr_en = we; wr_idx = wi; wr_tag = wt;
    wr_data = wd; clr = cl; r_ready = rr;
    #1;
    if (r_valid_or && r_ready) pop_check();
    if (q_valid && q_ready_or) begin
      push_exp(q_tag);
      accepts++;
    end
    if (cl) for (int i = 0; i < 8; i++) mv[i] = 1'b0;
    if (we) begin
      mv[wi] = 1'b1;
      mt[wi] = wt;
      md[wi] = wd;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic nop(input bit rr);
    cycle(1'b0, 4'd0, 1'b0, 3'd0, 4'd0, 3'd0, 1'b0, rr);
  endtask

  task automatic wr(input logic [2:0] wi, input logic [3:0] wt, input logic [2:0] wd);
    cycle(1'b0, 4'd0, 1'b1, wi, wt, wd, 1'b0, 1'b1);
  endtask

  task automatic query(input logic [3:0] qt);
    cycle(1'b1, qt, 1'b0, 3'd0, 4'd0, 3'd0, 1'b0, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      nop(1'b1);
      n++;
    end
    check("drain_timeout", 32'(sb.size()), 0);
    nop(1'b1);
    check("drain_idle_rvalid", r_valid_or, 0);
  endtask

  initial begin : main
    int n0;
    int a0;
    int stable_hits;
    got_t snap;
    bit   have_snap;

    rst_n = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_tag = '0; wr_data = '0;
    clr = 1'b0; q_valid = 1'b0; q_tag = '0; r_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_q_ready", q_ready_or, 1);
    check("rst_r_valid", r_valid_or, 0);
    check("rst_r_hit",   r_hit_or,   0);
    check("rst_r_multi", r_multi_or, 0);
    check("rst_r_idx",   r_idx_or,   0);
    check("rst_r_data",  r_data_or,  0);
    rst_n = 1'b1;
    @(negedge clk);

    // Empty table: all 16 tags miss, one result per cycle, latency 2
    n0 = got.size(); a0 = accepts;
    for (int t = 0; t < 16; t++) query(4'(t));
    check("empty_accepts", 32'(accepts - a0), 16);
    drain();
    check("empty_results", 32'(got.size() - n0), 16);
    for (int i = n0; i < got.size(); i++) begin
      check("empty_hit",  got[i].hit, 0);
      check("empty_idx",  got[i].idx, 0);
      check("empty_data", got[i].d0,  0);
    end

    // Two entries share tag 5: multi-hit, OR = 7, priority = entry 2 payload
    wr(3'd2, 4'd5, 3'd3);
    wr(3'd6, 4'd5, 3'd4);
    n0 = got.size();
    query(4'd5);
    drain();
    check("multi_hit",   got[n0].hit,   1);
    check("multi_multi", got[n0].multi, 1);
    check("multi_idx",   got[n0].idx,   2);
    check("multi_or",    got[n0].d0,    7);
    check("multi_prio",  got[n0].d1,    3);

    // Query sees the old entry when written in the same cycle
    n0 = got.size();
    cycle(1'b1, 4'd9, 1'b1, 3'd0, 4'd9, 3'd1, 1'b0, 1'b1);
    query(4'd9);
    drain();
    check("samecyc_miss",  got[n0].hit,     0);
    check("next_hit",      got[n0+1].hit,   1);
    check("next_multi",    got[n0+1].multi, 0);
    check("next_idx",      got[n0+1].idx,   0);
    check("next_data",     got[n0+1].d0,    1);

    // Back-pressure: two queries fill the pipe, outputs hold, then release
    n0 = got.size(); a0 = accepts;
    chk_lat = 1'b0;
    have_snap = 1'b0;
    stable_hits = 0;
    for (int i = 0; i < 5; i++) begin
      if (r_valid_or) begin
        if (!have_snap) begin
          snap.hit = r_hit_or; snap.multi = r_multi_or; snap.idx = r_idx_or;
          snap.d0 = r_data_or; snap.d1 = r_data_pri;
          have_snap = 1'b1;
        end else begin
          check("stall_hit",   r_hit_or,   snap.hit);
          check("stall_multi", r_multi_or, snap.multi);
          check("stall_idx",   r_idx_or,   snap.idx);
          check("stall_data",  r_data_or,  snap.d0);
          check("stall_pdata", r_data_pri, snap.d1);
          stable_hits++;
        end
      end
      cycle(1'b1, (i == 0) ? 4'd5 : (i == 1) ? 4'd9 : 4'd0,
            1'b0, 3'd0, 4'd0, 3'd0, 1'b0, 1'b0);
    end
    check("stall_accepts", 32'(accepts - a0), 2);
    check("stall_q_ready", q_ready_or, 0);
    check("stall_r_valid", r_valid_or, 1);
    check("stall_observed", 32'(stable_hits), 2);
    chk_lat = 1'b1;
    for (int i = 0; i < 4; i++) query(4'(i + 1));
    check("resume_accepts", 32'(accepts - a0), 6);
    drain();
    chk_lat = 1'b1;
    check("rel0_hit",  got[n0].hit,    1);
    check("rel0_idx",  got[n0].idx,    2);
    check("rel0_data", got[n0].d0,     7);
    check("rel1_hit",  got[n0+1].hit,  1);
    check("rel1_idx",  got[n0+1].idx,  0);
    check("rel1_data", got[n0+1].d1,   1);
    check("rel_count", 32'(got.size() - n0), 6);

    // Clear plus a write to entry 3 in one cycle: only tag 1 survives
    cycle(1'b0, 4'd0, 1'b1, 3'd3, 4'd1, 3'd5, 1'b1, 1'b1);
    n0 = got.size();
    query(4'd5);
    query(4'd9);
    query(4'd1);
    drain();
    check("clr_tag5",    got[n0].hit,     0);
    check("clr_tag9",    got[n0+1].hit,   0);
    check("clr_tag1",    got[n0+2].hit,   1);
    check("clr_idx",     got[n0+2].idx,   3);
    check("clr_data",    got[n0+2].d0,    5);

    // Asynchronous reset mid-stream
    query(4'd1);
    query(4'd1);
    rst_n = 1'b0;
    #1;
    check("arst_r_valid", r_valid_or, 0);
    check("arst_q_ready", q_ready_or, 1);
    check("arst_p_valid", r_valid_pri, 0);
    sb.delete();
    model_reset();
    q_valid = 1'b0; wr_en = 1'b0; clr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("arst_hold_valid", r_valid_or, 0);
    rst_n = 1'b1;
    @(negedge clk);
    n0 = got.size();
    query(4'd1);
    query(4'd5);
    drain();
    check("arst_tag1_miss", got[n0].hit,   0);
    check("arst_tag5_miss", got[n0+1].hit, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the bench always ends
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
